// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: two-port round-robin front end for one FP adder controller.
// One transaction is in flight at a time, moving IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
// Ports:
//   CLK, RST                         clock and synchronous active-high reset
//   Req_valid[1:0] / Req_ready[1:0]  request handshake (bit 0 = port A, bit 1 = port B)
//   ReqA_op1/op2/mode, ReqB_op1/op2/mode   operands and mode of each requester
//   Rsp_valid[1:0] / Rsp_ready[1:0]  response handshake for each requester
//   Rsp_data, Rsp_exc                response word and exception code, shared by both requesters
//   Add_datain1/2, Add_mode, Add_data_valid        command to the adder controller
//   Add_dataout, Add_exc, Add_dataout_valid        result from the adder controller
//   Busy                             high whenever the state is not IDLE
//   Timeout_flag                     sticky timeout indicator
// Optional feature: define FPU_ADD_ARB_TIMEOUT_EN to enable the WAIT watchdog.
//   The watchdog returns a quiet NaN with exception 3'b111 after TIMEOUT_CYCLES cycles in WAIT.
module fpu_add_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  Req_valid,
    output logic [1:0]  Req_ready,
    input  logic [31:0] ReqA_op1,
    input  logic [31:0] ReqA_op2,
    input  logic [31:0] ReqB_op1,
    input  logic [31:0] ReqB_op2,
    input  logic [2:0]  ReqA_mode,
    input  logic [2:0]  ReqB_mode,
    output logic [1:0]  Rsp_valid,
    input  logic [1:0]  Rsp_ready,
    output logic [31:0] Rsp_data,
    output logic [2:0]  Rsp_exc,
    output logic [31:0] Add_datain1,
    output logic [31:0] Add_datain2,
    output logic [2:0]  Add_mode,
    output logic        Add_data_valid,
    input  logic [31:0] Add_dataout,
    input  logic [2:0]  Add_exc,
    input  logic        Add_dataout_valid,
    output logic        Busy,
    output logic        Timeout_flag
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        gnt_q, gnt_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [2:0]  mode_q, mode_d;
    logic [31:0] res_q, res_d;
    logic [2:0]  exc_q, exc_d;
    logic        sel;
    logic        active;
`ifdef FPU_ADD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;
`endif
    // prio_q names the port that wins a tie; a lone requester always wins.
    assign sel    = (Req_valid == 2'b11) ? prio_q : (Req_valid == 2'b10);
    assign active = (state_q != IDLE);
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt_d   = gnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        mode_d  = mode_q;
        res_d   = res_q;
        exc_d   = exc_q;
`ifdef FPU_ADD_ARB_TIMEOUT_EN
        cnt_d   = '0;
        flag_d  = flag_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|Req_valid) begin
                    state_d = ISSUE;
                    gnt_d   = sel;
                    op1_d   = sel ? ReqB_op1 : ReqA_op1;
                    op2_d   = sel ? ReqB_op2 : ReqA_op2;
                    mode_d  = sel ? ReqB_mode : ReqA_mode;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (Add_dataout_valid) begin
                    state_d = RESPOND;
                    res_d   = Add_dataout;
                    exc_d   = Add_exc;
                end
`ifdef FPU_ADD_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RESPOND;
                    res_d   = 32'h7FC0_0000;
                    exc_d   = 3'b111;
                    flag_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESPOND: begin
                if (Rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                    prio_d  = ~gnt_q;
                end
            end
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            mode_q  <= '0;
            res_q   <= '0;
            exc_q   <= '0;
`ifdef FPU_ADD_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            flag_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
`ifdef FPU_ADD_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
`endif
        end
    end
    assign Req_ready      = (!active && |Req_valid) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign Add_data_valid = (state_q == ISSUE);
    assign Add_datain1    = active ? op1_q : '0;
    assign Add_datain2    = active ? op2_q : '0;
    assign Add_mode       = active ? mode_q : '0;
    assign Rsp_valid      = (state_q == RESPOND) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign Rsp_data       = (state_q == RESPOND) ? res_q : '0;
    assign Rsp_exc        = (state_q == RESPOND) ? exc_q : '0;
    assign Busy           = active;
`ifdef FPU_ADD_ARB_TIMEOUT_EN
    assign Timeout_flag   = flag_q;
`else
    assign Timeout_flag   = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb_fpu_add_arbiter: directed and randomized checks of fpu_add_arbiter against a behavioural model.
module tb_fpu_add_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  Req_valid = '0;
    logic [1:0]  Req_ready;
    logic [31:0] ReqA_op1 = '0, ReqA_op2 = '0, ReqB_op1 = '0, ReqB_op2 = '0;
    logic [2:0]  ReqA_mode = '0, ReqB_mode = '0;
    logic [1:0]  Rsp_valid;
    logic [1:0]  Rsp_ready = '0;
    logic [31:0] Rsp_data;
    logic [2:0]  Rsp_exc;
    logic [31:0] Add_datain1, Add_datain2;
    logic [2:0]  Add_mode;
    logic        Add_data_valid;
    logic [31:0] Add_dataout;
    logic [2:0]  Add_exc;
    logic        Add_dataout_valid;
    logic        Busy, Timeout_flag;

    int total = 0;
    int bad = 0;

    // adder controller stub: answers stub_lat cycles after the start pulse
    int          stub_lat = 5;
    logic        stub_fix = 1'b0, stub_mute = 1'b0;
    logic [31:0] stub_fd = '0;
    logic [2:0]  stub_fe = '0;
    int          cd = 0;
    logic [31:0] sd = '0;
    logic [2:0]  se = '0;

    fpu_add_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .RST(RST),
        .Req_valid(Req_valid), .Req_ready(Req_ready),
        .ReqA_op1(ReqA_op1), .ReqA_op2(ReqA_op2),
        .ReqB_op1(ReqB_op1), .ReqB_op2(ReqB_op2),
        .ReqA_mode(ReqA_mode), .ReqB_mode(ReqB_mode),
        .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready),
        .Rsp_data(Rsp_data), .Rsp_exc(Rsp_exc),
        .Add_datain1(Add_datain1), .Add_datain2(Add_datain2),
        .Add_mode(Add_mode), .Add_data_valid(Add_data_valid),
        .Add_dataout(Add_dataout), .Add_exc(Add_exc),
        .Add_dataout_valid(Add_dataout_valid),
        .Busy(Busy), .Timeout_flag(Timeout_flag)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (Add_data_valid && !stub_mute) begin
            cd <= stub_lat;
            sd <= stub_fix ? stub_fd : Add_datain1 + Add_datain2;
            se <= stub_fix ? stub_fe : Add_mode;
        end else if (cd != 0) begin
            cd <= cd - 1;
        end
    end
    assign Add_dataout_valid = (cd == 1);
    assign Add_dataout       = sd;
    assign Add_exc           = se;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {Req_ready, Rsp_valid, Add_data_valid, Busy, Rsp_exc, Add_mode}, '0);
        chk({tag, "_rsp"}, Rsp_data, '0);
        chk({tag, "_din"}, Add_datain1 | Add_datain2, '0);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (Rsp_valid == 2'b00 && n < 60) begin
            tick;
            n++;
        end
    endtask

    // waits for the grant to port p, then completes the transaction and checks its response
    task automatic serve(input string tag, input int p, input logic [31:0] ed, input logic [2:0] ee);
        logic [1:0] e;
        int n;
        e = (p == 1) ? 2'b10 : 2'b01;
        n = 0;
        #1;
        while (Req_ready == 2'b00 && n < 40) begin
            tick;
            #1;
            n++;
        end
        chk({tag, "_gnt"}, Req_ready, e);
        tick;
        wait_rsp(n);
        chk({tag, "_rv"}, Rsp_valid, e);
        chk({tag, "_rd"}, Rsp_data, ed);
        chk({tag, "_re"}, Rsp_exc, ee);
        chk({tag, "_nogrant"}, Req_ready, 2'b00);
        Rsp_ready = e;
        tick;
        Rsp_ready = 2'b00;
    endtask

    int          n, lat, g, prio, h;
    logic [1:0]  pat, e;
    logic [31:0] a1, a2, b1, b2, xd;
    logic [2:0]  am, bm, xe;

    initial begin
        // reset state
        repeat (2) tick;
        chk_quiet("rst");
        chk("rst_to", Timeout_flag, 0);
        RST = 1'b0;
        tick;
        chk_quiet("post_rst");
        chk("post_rst_to", Timeout_flag, 0);

        // single request with exact latency
        stub_fix = 1'b1; stub_fd = 32'h4040_0000; stub_fe = 3'b000; stub_lat = 5;
        Req_valid = 2'b01; ReqA_op1 = 32'h3F80_0000; ReqA_op2 = 32'h4000_0000; ReqA_mode = 3'b001;
        #1;
        chk("s_rdy", Req_ready, 2'b01);
        chk("s_busy0", Busy, 0);
        tick;
        Req_valid = 2'b00;
        chk("s_adv", Add_data_valid, 1);
        chk("s_din1", Add_datain1, 32'h3F80_0000);
        chk("s_din2", Add_datain2, 32'h4000_0000);
        chk("s_mode", Add_mode, 3'b001);
        chk("s_busy1", Busy, 1);
        wait_rsp(n);
        chk("s_lat", n, 6);
        chk("s_rv", Rsp_valid, 2'b01);
        chk("s_rd", Rsp_data, 32'h4040_0000);
        chk("s_re", Rsp_exc, 3'b000);
        chk("s_hold", Add_datain1, 32'h3F80_0000);
        Rsp_ready = 2'b01;
        tick;
        Rsp_ready = 2'b00;
        chk_quiet("s_done");

        // contention after reset: A, B, A, B
        RST = 1'b1; tick; RST = 1'b0; tick;
        stub_fix = 1'b0; stub_lat = 3;
        ReqA_op1 = 32'h1111_0000; ReqA_op2 = 32'h0000_2222; ReqA_mode = 3'b011;
        ReqB_op1 = 32'h0A00_0000; ReqB_op2 = 32'h00B0_0000; ReqB_mode = 3'b101;
        Req_valid = 2'b11;
        serve("c0", 0, 32'h1111_2222, 3'b011);
        serve("c1", 1, 32'h0AB0_0000, 3'b101);
        serve("c2", 0, 32'h1111_2222, 3'b011);
        serve("c3", 1, 32'h0AB0_0000, 3'b101);
        Req_valid = 2'b00;

        // backpressure on port B while A waits
        Req_valid = 2'b10;
        #1;
        chk("bp_gnt", Req_ready, 2'b10);
        tick;
        Req_valid = 2'b01;
        wait_rsp(n);
        for (int i = 0; i < 10; i++) begin
            Rsp_ready = 2'b01;
            #1;
            chk("bp_rv", Rsp_valid, 2'b10);
            chk("bp_rd", Rsp_data, 32'h0AB0_0000);
            chk("bp_rdy", Req_ready, 2'b00);
            chk("bp_busy", Busy, 1);
            tick;
        end
        Rsp_ready = 2'b10;
        tick;
        Rsp_ready = 2'b00;
        #1;
        chk("bp_next", Req_ready, 2'b01);
        serve("bp_a", 0, 32'h1111_2222, 3'b011);
        Req_valid = 2'b00;

        // reset in WAIT, late adder result must be ignored
        stub_lat = 5;
        Req_valid = 2'b01;
        tick;
        Req_valid = 2'b00;
        tick;
        tick;
        RST = 1'b1;
        tick;
        chk_quiet("mw_rst");
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk_quiet("mw_after");
        end

        // exception pass-through on port B
        stub_fix = 1'b1; stub_fd = 32'h7F80_0000; stub_fe = 3'b010; stub_lat = 2;
        Req_valid = 2'b10;
        serve("exc", 1, 32'h7F80_0000, 3'b010);
        Req_valid = 2'b00;

        // adder never answers
        stub_fix = 1'b0; stub_mute = 1'b1;
        Req_valid = 2'b01;
        tick;
        Req_valid = 2'b00;
`ifdef FPU_ADD_ARB_TIMEOUT_EN
        wait_rsp(n);
        chk("to_lat", n, 9);
        chk("to_rv", Rsp_valid, 2'b01);
        chk("to_rd", Rsp_data, 32'h7FC0_0000);
        chk("to_re", Rsp_exc, 3'b111);
        chk("to_flag", Timeout_flag, 1);
        Rsp_ready = 2'b01;
        tick;
        Rsp_ready = 2'b00;
        chk("to_sticky", Timeout_flag, 1);
        chk("to_idle", Busy, 0);
`else
        repeat (100) tick;
        chk("nto_busy", Busy, 1);
        chk("nto_rv", Rsp_valid, 2'b00);
        chk("nto_flag", Timeout_flag, 0);
`endif
        stub_mute = 1'b0;
        RST = 1'b1; tick; RST = 1'b0;
        chk("to_clr", Timeout_flag, 0);
        tick;

        // randomized traffic against the arbitration model
        prio = 0;
        for (int it = 0; it < 25; it++) begin
            pat = 2'($urandom_range(1, 3));
            a1 = $urandom; a2 = $urandom; b1 = $urandom; b2 = $urandom;
            am = 3'($urandom); bm = 3'($urandom);
            lat = $urandom_range(1, 6);
            stub_lat = lat;
            ReqA_op1 = a1; ReqA_op2 = a2; ReqA_mode = am;
            ReqB_op1 = b1; ReqB_op2 = b2; ReqB_mode = bm;
            Req_valid = pat;
            g = (pat == 2'b11) ? prio : (pat == 2'b10 ? 1 : 0);
            e = (g == 1) ? 2'b10 : 2'b01;
            xd = (g == 1) ? b1 + b2 : a1 + a2;
            xe = (g == 1) ? bm : am;
            #1;
            chk("r_gnt", Req_ready, e);
            tick;
            Req_valid = 2'b00;
            chk("r_adv", Add_data_valid, 1);
            chk("r_din1", Add_datain1, (g == 1) ? b1 : a1);
            wait_rsp(n);
            chk("r_lat", n, lat + 1);
            chk("r_rv", Rsp_valid, e);
            chk("r_rd", Rsp_data, xd);
            chk("r_re", Rsp_exc, xe);
            h = $urandom_range(0, 3);
            for (int i = 0; i < h; i++) begin
                Rsp_ready = ~e;
                tick;
                chk("r_stable", {Rsp_valid, Rsp_data}, {e, xd});
            end
            Rsp_ready = e;
            tick;
            Rsp_ready = 2'b00;
            chk("r_done", Busy, 0);
            prio = 1 - g;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
